// File: rtl/vid_hseq.sv
// Horizontal timing sequencer: an 11-bit pixel counter is compared against
// programmable period, blank and sync registers to produce the line strobes.
module vid_hseq #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         resetl,
  input  logic         enable,
  input  logic         reg_wr,
  input  logic [2:0]   reg_addr,
  input  logic [W-1:0] reg_data,
  output logic [W-1:0] hcount,
  output logic         hblank,
  output logic         hsync,
  output logic         half_line,
  output logic         line_end,
  output logic         o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_hp, r_hbb, r_hbe, r_hss, r_hse;
  logic         w_wrap;
  logic         w_half_hit;

  // The all-ones term bounds the line when HP is programmed below the count.
  assign w_wrap      = (hcount == r_hp) || (hcount == {W{1'b1}});
  assign w_half_hit  = (hcount == (r_hp >> 1));
  assign o_dbg_state = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_hp  <= W'(844);
      r_hbb <= W'(640);
      r_hbe <= W'(844);
      r_hss <= W'(656);
      r_hse <= W'(752);
    end else if (reg_wr) begin
      case (reg_addr)
        3'd0:    r_hp  <= reg_data;
        3'd1:    r_hbb <= reg_data;
        3'd2:    r_hbe <= reg_data;
        3'd3:    r_hss <= reg_data;
        3'd4:    r_hse <= reg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state   <= ST_IDLE;
      hcount    <= '0;
      hblank    <= 1'b1;
      hsync     <= 1'b0;
      half_line <= 1'b0;
      line_end  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          hcount    <= '0;
          hblank    <= 1'b1;
          hsync     <= 1'b0;
          half_line <= 1'b0;
          line_end  <= 1'b0;
          if (enable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            r_state   <= ST_IDLE;
            hcount    <= '0;
            hblank    <= 1'b1;
            hsync     <= 1'b0;
            half_line <= 1'b0;
            line_end  <= 1'b0;
          end else begin
            hcount    <= w_wrap ? '0 : hcount + W'(1);
            line_end  <= w_wrap;
            half_line <= w_half_hit;
            // Set is tested first so equal begin/end registers latch high.
            if (hcount == r_hbb)      hblank <= 1'b1;
            else if (hcount == r_hbe) hblank <= 1'b0;
            if (hcount == r_hss)      hsync  <= 1'b1;
            else if (hcount == r_hse) hsync  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_hseq.sv
// Directed bench for vid_hseq: a cycle model feeds an expected-output queue
// checked every cycle, plus line-shape checks against fixed timing values.
module tb_vid_hseq;
  localparam int W = 11;

  logic         clk;
  logic         resetl;
  logic         enable;
  logic         reg_wr;
  logic [2:0]   reg_addr;
  logic [W-1:0] reg_data;
  logic [W-1:0] hcount;
  logic         hblank, hsync, half_line, line_end, o_dbg_state;

  vid_hseq #(.W(W)) dut (
    .clk(clk), .resetl(resetl), .enable(enable), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_data(reg_data), .hcount(hcount),
    .hblank(hblank), .hsync(hsync), .half_line(half_line),
    .line_end(line_end), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {hcount, hblank, hsync, half_line, line_end, state}
  logic [W+4:0] exp_q[$];

  logic [W-1:0] m_hc;
  logic         m_hb, m_hs, m_hl, m_le, m_run;
  logic [W-1:0] m_reg[5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hc = '0; m_hb = 1'b1; m_hs = 1'b0; m_hl = 1'b0; m_le = 1'b0; m_run = 1'b0;
    m_reg[0] = 11'd844; m_reg[1] = 11'd640; m_reg[2] = 11'd844;
    m_reg[3] = 11'd656; m_reg[4] = 11'd752;
  endtask

  task automatic model_edge();
    logic wrap;
    if (!m_run) begin
      m_hc = '0; m_hb = 1'b1; m_hs = 1'b0; m_hl = 1'b0; m_le = 1'b0;
      if (enable) m_run = 1'b1;
    end else if (!enable) begin
      m_run = 1'b0;
      m_hc = '0; m_hb = 1'b1; m_hs = 1'b0; m_hl = 1'b0; m_le = 1'b0;
    end else begin
      wrap = (m_hc == m_reg[0]) || (m_hc == 11'h7FF);
      m_le = wrap;
      m_hl = (m_hc == (m_reg[0] >> 1));
      if (m_hc == m_reg[1])      m_hb = 1'b1;
      else if (m_hc == m_reg[2]) m_hb = 1'b0;
      if (m_hc == m_reg[3])      m_hs = 1'b1;
      else if (m_hc == m_reg[4]) m_hs = 1'b0;
      m_hc = wrap ? '0 : m_hc + 11'd1;
    end
    if (reg_wr && reg_addr < 3'd5) m_reg[reg_addr] = reg_data;
  endtask

  // One clock: model advances at the edge, DUT checked at the falling edge.
  task automatic tick();
    logic [W+4:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_hc, m_hb, m_hs, m_hl, m_le, m_run});
    @(negedge clk);
    e = exp_q.pop_front();
    check("cycle", 32'({hcount, hblank, hsync, half_line, line_end, o_dbg_state}), 32'(e));
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_data = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic wait_hc(input int v, input int budget);
    int n = 0;
    while (hcount !== W'(v) && n < budget) begin tick(); n++; end
    check("wait_hcount", 32'(hcount), 32'(v));
  endtask

  task automatic wait_le(input int budget);
    int n = 0;
    while (line_end !== 1'b1 && n < budget) begin tick(); n++; end
    check("wait_line_end", 32'(line_end), 32'd1);
  endtask

  // Starting on a line_end cycle, run one full line and record its shape.
  task automatic measure_line(input int budget, output int len,
                              output int hb_first, output int hb_last,
                              output int hs_first, output int hs_last,
                              output int hl_at, output int hb_low, output int hs_low);
    len = 0; hb_first = -1; hb_last = -1; hs_first = -1; hs_last = -1;
    hl_at = -1; hb_low = 0; hs_low = 0;
    while (len < budget) begin
      tick();
      len++;
      if (line_end === 1'b1) break;
      if (hblank === 1'b1) begin
        if (hb_first < 0) hb_first = int'(hcount);
        hb_last = int'(hcount);
      end else hb_low++;
      if (hsync === 1'b1) begin
        if (hs_first < 0) hs_first = int'(hcount);
        hs_last = int'(hcount);
      end else hs_low++;
      if (half_line === 1'b1) hl_at = int'(hcount);
    end
  endtask

  initial begin
    int len, hbf, hbl, hsf, hsl, hla, hbz, hsz, n, prev;
    int pos[2];
    resetl = 1'b0; enable = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    resetl = 1'b1;

    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_hblank", 32'(hblank), 32'd1);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_pulses", 32'({half_line, line_end}), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);

    // default timing
    enable = 1'b1;
    tick();
    check("first_run_hcount", 32'(hcount), 32'd0);
    check("first_run_no_le", 32'(line_end), 32'd0);
    wait_le(2000);
    measure_line(2000, len, hbf, hbl, hsf, hsl, hla, hbz, hsz);
    check("def_len", len, 845);
    check("def_hb_first", hbf, 641);
    check("def_hb_last", hbl, 844);
    check("def_hb_fall", 32'(hblank), 32'd0);
    check("def_hs_first", hsf, 657);
    check("def_hs_last", hsl, 752);
    check("def_half", hla, 423);

    // short line
    wr(3'd0, 11'd9); wr(3'd1, 11'd6); wr(3'd2, 11'd9); wr(3'd3, 11'd7); wr(3'd4, 11'd8);
    wait_le(3000);
    measure_line(100, len, hbf, hbl, hsf, hsl, hla, hbz, hsz);
    check("hp9_len", len, 10);
    check("hp9_hb_first", hbf, 7);
    check("hp9_hb_last", hbl, 9);
    check("hp9_hs_first", hsf, 8);
    check("hp9_hs_last", hsl, 8);
    check("hp9_half", hla, 5);

    // period written below the current count
    wr(3'd0, 11'd844); wr(3'd1, 11'd640); wr(3'd2, 11'd844); wr(3'd3, 11'd656); wr(3'd4, 11'd752);
    wait_hc(500, 3000);
    wr(3'd0, 11'd100);
    n = 0; prev = -1;
    while (line_end !== 1'b1 && n < 3000) begin prev = int'(hcount); tick(); n++; end
    check("overrun_cycles", n, 1547);
    check("overrun_last", prev, 2047);
    measure_line(3000, len, hbf, hbl, hsf, hsl, hla, hbz, hsz);
    check("hp100_len", len, 101);

    // disable mid-line, then restart
    wr(3'd0, 11'd844);
    pos[0] = 300; pos[1] = 700;
    for (int i = 0; i < 2; i++) begin
      wait_hc(pos[i], 3000);
      enable = 1'b0;
      tick();
      check("dis_hcount", 32'(hcount), 32'd0);
      check("dis_hblank", 32'(hblank), 32'd1);
      check("dis_hsync", 32'(hsync), 32'd0);
      check("dis_no_le", 32'(line_end), 32'd0);
      check("dis_state", 32'(o_dbg_state), 32'd0);
      repeat (2) tick();
      enable = 1'b1;
      tick();
      check("reen_hcount0", 32'(hcount), 32'd0);
      check("reen_state", 32'(o_dbg_state), 32'd1);
      tick();
      check("reen_hcount1", 32'(hcount), 32'd1);
    end

    // HP=0 written while idle: both pulses every cycle
    enable = 1'b0;
    tick();
    wr(3'd0, 11'd0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hp0_pulses", 32'({hcount, half_line, line_end}), 32'd3);
    end

    // equal set/clear compares: set wins
    wr(3'd0, 11'd844); wr(3'd1, 11'd20); wr(3'd2, 11'd20); wr(3'd3, 11'd30); wr(3'd4, 11'd30);
    wait_le(3000);
    measure_line(2000, len, hbf, hbl, hsf, hsl, hla, hbz, hsz);
    check("eq_len", len, 845);
    check("eq_hb_low", hbz, 0);
    check("eq_hs_low", hsz, 0);

    // asynchronous reset pulse between edges
    wr(3'd0, 11'd9);
    wait_hc(5, 100);
    #2 resetl = 1'b0;
    model_reset();
    #1;
    check("arst_hcount", 32'(hcount), 32'd0);
    check("arst_hblank", 32'(hblank), 32'd1);
    check("arst_hsync", 32'(hsync), 32'd0);
    check("arst_pulses", 32'({half_line, line_end}), 32'd0);
    check("arst_state", 32'(o_dbg_state), 32'd0);
    #1 resetl = 1'b1;
    wait_le(2000);
    measure_line(2000, len, hbf, hbl, hsf, hsl, hla, hbz, hsz);
    check("arst_len", len, 845);
    check("arst_hb_first", hbf, 641);
    check("arst_hs_first", hsf, 657);
    check("arst_hs_last", hsl, 752);
    check("arst_half", hla, 423);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
